// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler that owns the select pair of a shared 4:1 WIDTH-bit mux
// and registers the granted requester's beats into one backpressured output stage.
module mux4_rr_scheduler #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [3:0]       grant,
  output logic             sel0,
  output logic             sel1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [3:0]       grant_r, grant_s;
  logic [3:0]       count_r, count_s;
  logic [WIDTH-1:0] data_r, data_s, sel_data_s;
  logic             valid_r, valid_s;
  logic             can_accept_s;
  logic             xfer_s;
  logic [3:0]       ready_s;

  // First set requester after the last grant, wrapping around; last grant is lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
    logic [1:0] cand;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && v[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Source mux driven by the registered select.
  always_comb begin
    case (idx_r)
      2'd0:    sel_data_s = req_data0;
      2'd1:    sel_data_s = req_data1;
      2'd2:    sel_data_s = req_data2;
      2'd3:    sel_data_s = req_data3;
      default: sel_data_s = req_data0;
    endcase
  end

  // Arbitration FSM next state, burst accounting and output stage update.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    grant_s      = grant_r;
    count_s      = count_r;
    data_s       = data_r;
    valid_s      = valid_r;
    can_accept_s = !valid_r || out_ready;
    ready_s      = 4'b0000;
    xfer_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (req_valid != 4'b0000) begin
          idx_s   = rr_pick(req_valid, idx_r);
          grant_s = 4'b0001 << idx_s;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        ready_s = grant_r & {4{can_accept_s}};
        xfer_s  = req_valid[idx_r] && can_accept_s;
        // idx_r is kept on release so it serves as last_grant for the next scan.
        if (!req_valid[idx_r] ||
            (xfer_s && (req_last[idx_r] || count_r == LAST_BEAT))) begin
          state_s = IDLE;
          grant_s = 4'b0000;
          count_s = 4'd0;
        end else if (xfer_s) begin
          count_s = count_r + 4'd1;
        end else begin
          count_s = count_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 4'b0000;
        count_s = 4'd0;
      end
    endcase

    if (xfer_s) begin
      data_s  = sel_data_s;
      valid_s = 1'b1;
    end else if (out_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State and output registers; reset parks the select on requester 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 2'd3;
      grant_r <= 4'b0000;
      count_r <= 4'd0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      grant_r <= grant_s;
      count_r <= count_s;
      data_r  <= data_s;
      valid_r <= valid_s;
    end
  end

  assign req_ready = ready_s;
  assign grant     = grant_r;
  assign sel0      = idx_r[1];
  assign sel1      = idx_r[0];
  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign busy      = (state_r == GRANT);

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler: round-robin cycling, single bursts,
// backpressure, abandon, mid-burst reset and back-to-back throughput.
module tb_mux4_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] req_ready;
  logic [3:0] grant;
  logic       sel0, sel1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_vec;
  int n_err;

  mux4_rr_scheduler #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
    .req_ready(req_ready), .grant(grant), .sel0(sel0), .sel1(sel1),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] v);
    case (idx)
      0:       d0 = v;
      1:       d1 = v;
      2:       d2 = v;
      default: d3 = v;
    endcase
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; req_valid = 4'b0000; req_last = 4'b0000; out_ready = 1'b1;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_grant", {28'd0, grant}, 32'd0);
    check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sel", {30'd0, sel0, sel1}, 32'd3);
    check_eq("rst_oval", {31'd0, out_valid}, 32'd0);
    check_eq("rst_odata", {24'd0, out_data}, 32'd0);
    rst_n = 1'b1;

    // Four-way request: grants 0,1,2,3,0 with 4 beats each, back-to-back beats.
    req_valid = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      int g;
      g = p % 4;
      tick();
      check_eq("rr_grant", {28'd0, grant}, 32'd1 << g);
      check_eq("rr_sel", {30'd0, sel0, sel1}, 32'(g));
      check_eq("rr_busy", {31'd0, busy}, 32'd1);
      for (int b = 0; b < 4; b++) begin
        set_data(g, 8'((g << 4) + b));
        #1;
        check_eq("rr_ready", {28'd0, req_ready}, 32'd1 << g);
        tick();
        check_eq("rr_oval", {31'd0, out_valid}, 32'd1);
        check_eq("rr_odata", {24'd0, out_data}, 32'((g << 4) + b));
      end
      check_eq("rr_rel_grant", {28'd0, grant}, 32'd0);
      check_eq("rr_rel_busy", {31'd0, busy}, 32'd0);
      if (p == 4) req_valid = 4'b0000;
    end
    tick();
    check_eq("rr_drain", {31'd0, out_valid}, 32'd0);

    // Requester 2 alone, 2-beat burst ended by req_last.
    req_valid = 4'b0100; d2 = 8'hA1;
    tick();
    check_eq("r2_grant", {28'd0, grant}, 32'h4);
    check_eq("r2_sel", {30'd0, sel0, sel1}, 32'd2);
    tick();
    check_eq("r2_b0", {24'd0, out_data}, 32'hA1);
    d2 = 8'hA2; req_last = 4'b0100;
    tick();
    check_eq("r2_b1", {24'd0, out_data}, 32'hA2);
    check_eq("r2_b1_val", {31'd0, out_valid}, 32'd1);
    check_eq("r2_idle_grant", {28'd0, grant}, 32'd0);
    check_eq("r2_idle_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'b0000; req_last = 4'b0000;
    tick();
    check_eq("r2_drain", {31'd0, out_valid}, 32'd0);

    // Requester 1 with a 3-cycle stall after the first beat; count must not move.
    req_valid = 4'b0010; d1 = 8'h55;
    tick();
    check_eq("r1_grant", {28'd0, grant}, 32'h2);
    tick();
    check_eq("r1_b0", {24'd0, out_data}, 32'h55);
    out_ready = 1'b0; d1 = 8'h66;
    #1;
    check_eq("r1_stall_ready0", {28'd0, req_ready}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq("r1_stall_val", {31'd0, out_valid}, 32'd1);
      check_eq("r1_stall_data", {24'd0, out_data}, 32'h55);
      check_eq("r1_stall_ready", {28'd0, req_ready}, 32'd0);
      check_eq("r1_stall_grant", {28'd0, grant}, 32'h2);
    end
    out_ready = 1'b1;
    #1;
    check_eq("r1_resume_ready", {28'd0, req_ready}, 32'h2);
    tick();
    check_eq("r1_b1", {24'd0, out_data}, 32'h66);
    d1 = 8'h77;
    tick();
    check_eq("r1_b2", {24'd0, out_data}, 32'h77);
    check_eq("r1_b2_grant", {28'd0, grant}, 32'h2);
    d1 = 8'h88;
    tick();
    check_eq("r1_b3", {24'd0, out_data}, 32'h88);
    check_eq("r1_b3_rel", {28'd0, grant}, 32'd0);
    req_valid = 4'b0000;
    tick();

    // Requester 3 abandons after one beat; requester 0 is next after last_grant=3.
    req_valid = 4'b1000; d3 = 8'hC3;
    tick();
    check_eq("r3_grant", {28'd0, grant}, 32'h8);
    tick();
    check_eq("r3_b0", {24'd0, out_data}, 32'hC3);
    req_valid = 4'b0011;
    tick();
    check_eq("r3_abandon_grant", {28'd0, grant}, 32'd0);
    check_eq("r3_abandon_val", {31'd0, out_valid}, 32'd0);
    tick();
    check_eq("r0_after_r3", {28'd0, grant}, 32'h1);
    check_eq("r0_after_r3_sel", {30'd0, sel0, sel1}, 32'd0);

    // Reset while a beat sits unconsumed in the output stage.
    d0 = 8'hD0; out_ready = 1'b0;
    tick();
    check_eq("pre_rst_val", {31'd0, out_valid}, 32'd1);
    check_eq("pre_rst_data", {24'd0, out_data}, 32'hD0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_val", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_grant", {28'd0, grant}, 32'd0);
    check_eq("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    check_eq("mid_rst_sel", {30'd0, sel0, sel1}, 32'd3);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    #1 rst_n = 1'b1; out_ready = 1'b1; req_valid = 4'b1111;
    tick();
    check_eq("post_rst_grant", {28'd0, grant}, 32'h1);
    req_valid = 4'b0000;
    tick();
    check_eq("post_rst_rel", {28'd0, grant}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
